// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional FIFO_WR_ARB_THROTTLE_EN: limit bursts to one beat while fifo_threshold is high.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_threshold,
  output logic                          wen,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, owner_inc, start, win;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt, limit;
  logic found, burst_end;
  // Scanning backwards lets the earliest index in search order win.
  function automatic logic [IW:0] pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] s);
    logic [IW:0] r;
    int idx;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(s) + k) % NUM_REQ;
      if (v[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction
`ifdef FIFO_WR_ARB_THROTTLE_EN
  assign limit = fifo_threshold ? CW'(1) : CW'(BURST_MAX);
`else
  logic unused_threshold;
  assign unused_threshold = fifo_threshold;
  assign limit = CW'(BURST_MAX);
`endif
  assign owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  // At burst end the outgoing owner is searched last.
  assign start = (state == GRANT) ? owner_inc : rr_ptr;
  assign {found, win} = pick(req_valid, start);
  assign burst_end = (wen && (burst_cnt + CW'(1)) == limit) || !req_valid[owner];
  assign grant_id = owner;
  assign busy = (state == GRANT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt + CW'(wen);
    if (state == IDLE || burst_end) begin
      rr_ptr_nxt    = (state == GRANT) ? owner_inc : rr_ptr;
      state_nxt     = found ? GRANT : IDLE;
      owner_nxt     = found ? win : owner;
      burst_cnt_nxt = '0;
    end
  end
  // Gating with rst keeps a dropped burst from writing in the reset cycle.
  always_comb begin
    req_ready        = '0;
    req_ready[owner] = !rst && state == GRANT && !fifo_full;
    wen              = req_valid[owner] && req_ready[owner];
    data_in          = (state == GRANT) ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random checks of fifo_wr_arbiter against a behavioural model.
module tb_fifo_wr_arbiter;
`ifdef FIFO_WR_ARB_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0] req_ready;
  logic fifo_full = 1'b0;
  logic fifo_threshold = 1'b0;
  logic wen;
  logic [7:0] data_in;
  logic [1:0] grant_id;
  logic busy;
  int total = 0;
  int bad = 0;
  logic [7:0] dat [4];
  logic [9:0] wq [$];
  bit m_busy = 1'b0;
  int m_own = 0;
  int m_ptr = 0;
  int m_beats = 0;

  fifo_wr_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_threshold(fifo_threshold),
    .wen(wen), .data_in(data_in), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int find(input logic [3:0] v, input int s);
    for (int k = 0; k < 4; k++)
      if (v[(s + k) % 4]) return (s + k) % 4;
    return -1;
  endfunction

  task automatic step(input logic [3:0] v, input logic f, input logic t, input logic r);
    logic [3:0] er;
    logic ew;
    int w, lim;
    @(posedge clk);
    #1;
    req_valid = v; fifo_full = f; fifo_threshold = t; rst = r;
    req_data = {dat[3], dat[2], dat[1], dat[0]};
    #4;
    er = (!r && m_busy && !f) ? 4'(1 << m_own) : 4'b0;
    ew = m_busy && er[m_own] && v[m_own];
    chk("ready", 32'(req_ready), 32'(er));
    chk("wen", 32'(wen), 32'(ew));
    chk("grant_id", 32'(grant_id), 32'(m_own));
    chk("busy", 32'(busy), 32'(m_busy));
    if (ew) chk("data", 32'(data_in), 32'(dat[m_own]));
    if (wen) wq.push_back({grant_id, data_in});
    if (r) begin
      m_busy = 1'b0; m_own = 0; m_ptr = 0; m_beats = 0;
    end else if (!m_busy) begin
      w = find(v, m_ptr);
      if (w >= 0) begin m_busy = 1'b1; m_own = w; m_beats = 0; end
    end else begin
      if (ew) begin m_beats++; dat[m_own] = dat[m_own] + 8'd1; end
      lim = (THR && t) ? 1 : 4;
      if ((ew && m_beats == lim) || !v[m_own]) begin
        m_ptr = (m_own + 1) % 4;
        w = find(v, m_ptr);
        if (w >= 0) begin m_own = w; m_beats = 0; end
        else m_busy = 1'b0;
      end
    end
  endtask

  task automatic reset_clear();
    step(4'b0000, 1'b0, 1'b0, 1'b1);
    wq.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dat[i] = 8'(8'h20 * (i + 1));
    reset_clear();
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rst_outs", {22'd0, req_ready, wen, data_in}, 32'd0);
    dat[0] = 8'h10;
    repeat (9) step(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("single_n", wq.size(), 8);
    for (int k = 0; k < wq.size(); k++) chk("single_wr", 32'(wq[k]), 32'({2'd0, 8'(8'h10 + k)}));
    reset_clear();
    repeat (21) step(4'b1111, 1'b0, 1'b0, 1'b0);
    chk("all_n", wq.size(), 20);
    for (int k = 0; k < wq.size(); k++) chk("all_owner", 32'(wq[k][9:8]), 32'((k / 4) % 4));
    reset_clear();
    repeat (3) step(4'b0011, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'b0011, 1'b1, 1'b0, 1'b0);
    repeat (3) step(4'b0011, 1'b0, 1'b0, 1'b0);
    chk("stall_n", wq.size(), 5);
    for (int k = 0; k < wq.size(); k++) chk("stall_owner", 32'(wq[k][9:8]), (k < 4) ? 0 : 1);
    reset_clear();
    repeat (2) step(4'b1100, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 1'b0);
    chk("drop_gid", 32'(grant_id), 32'd3);
    reset_clear();
    repeat (2) step(4'b0010, 1'b0, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0);
    chk("midrst_outs", {20'd0, req_ready, wen, busy, grant_id, data_in}, 32'd0);
    step(4'b0011, 1'b0, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0, 1'b0);
    chk("midrst_restart", 32'(grant_id), 32'd0);
    reset_clear();
    repeat (9) step(4'b0011, 1'b0, 1'b1, 1'b0);
    chk("thr_n", wq.size(), 8);
    for (int k = 0; k < wq.size(); k++)
      chk("thr_owner", 32'(wq[k][9:8]), THR ? k % 2 : (k / 4) % 2);
    reset_clear();
    for (int n = 0; n < 3000; n++)
      step(4'($urandom), ($urandom % 5) == 0, 1'($urandom), ($urandom % 100) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
